vga_scanout: RTL and testbench

- Display-side timing generator and pixel sink for the memory block's display port.
- Produces the `pixel_x`/`pixel_y` scan coordinates that the memory block uses to fetch tiles.
- Receives the resulting 12-bit `pixel` a fixed 2 clocks later.
- Re-aligns that pixel with delayed hsync/vsync/blank and drives the 4:4:4 VGA pins.
- Default timing is 640x480@60 from a 100 MHz `clk`, using a pixel-enable divider.

---
 rtl/vga_pkg.sv | 20 ++
 rtl/vga_scanout_delay_line.sv | 23 ++
 rtl/vga_scanout.sv | 102 ++++++++++
 tb/tb_vga_scanout.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: 640x480@60 timing constants, RGB444 width and test-bar colours
package vga_pkg;
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP = 16;
  localparam int VGA_H_SYNC = 96;
  localparam int VGA_H_BP = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP = 10;
  localparam int VGA_V_SYNC = 2;
  localparam int VGA_V_BP = 33;
  localparam int H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
  localparam int RGB_W = 12;
  localparam logic [8*RGB_W-1:0] BAR_COLORS = {
    12'h000, 12'h00F, 12'hF00, 12'hF0F, 12'h0F0, 12'h0FF, 12'hFF0, 12'hFFF
  };
  function automatic logic [RGB_W-1:0] bar_color(input logic [2:0] idx);
    return BAR_COLORS[idx*RGB_W +: RGB_W];
  endfunction
endpackage

// File: rtl/vga_scanout_delay_line.sv
// delay_line: DEPTH-stage register pipe with synchronous clear
module delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [DEPTH-1:0][WIDTH-1:0] pipe_q, pipe_d;
  // Shift every clock, newest sample enters stage 0
  always_comb begin
    pipe_d[0] = d;
    for (int i = 1; i < DEPTH; i++) pipe_d[i] = pipe_q[i-1];
  end
  // Pipe registers
  always_ff @(posedge clk) begin
    if (rst) pipe_q <= '0;
    else pipe_q <= pipe_d;
  end
  assign q = pipe_q[DEPTH-1];
endmodule

// File: rtl/vga_scanout.sv
// vga_scanout: VGA timing generator and pixel sink; define VGA_TEST_PATTERN_EN to replace pixel with colour bars
module vga_scanout
  import vga_pkg::*;
#(
  parameter int   CLK_DIV  = 4,
  parameter int   MEM_LAT  = 2,
  parameter int   H_ACTIVE = VGA_H_ACTIVE,
  parameter int   H_FP     = VGA_H_FP,
  parameter int   H_SYNC   = VGA_H_SYNC,
  parameter int   H_BP     = VGA_H_BP,
  parameter int   V_ACTIVE = VGA_V_ACTIVE,
  parameter int   V_FP     = VGA_V_FP,
  parameter int   V_SYNC   = VGA_V_SYNC,
  parameter int   V_BP     = VGA_V_BP,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  output logic [9:0]       pixel_x,
  output logic [9:0]       pixel_y,
  input  logic [RGB_W-1:0] pixel,
  output logic [3:0]       vga_r,
  output logic [3:0]       vga_g,
  output logic [3:0]       vga_b,
  output logic             vga_hsync,
  output logic             vga_vsync,
  output logic             vblank
);
  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS0 = H_ACTIVE + H_FP;
  localparam int VS0 = V_ACTIVE + V_FP;
  localparam int DW = $clog2(CLK_DIV);
  logic [DW-1:0] div_q, div_d;
  logic [9:0] h_q, h_d, v_q, v_d;
  logic tick, h_last, active, hs, vs, vb;
  logic [3:0] flags_a;
  logic active_a, hs_a, vs_a, vb_a;
  logic [RGB_W-1:0] src, rgb_q, rgb_d;
  logic hsync_q, hsync_d, vsync_q, vsync_d, vblank_q, vblank_d;
  // Pixel-enable divider and scan counters advancing on tick
  always_comb begin
    tick = div_q == DW'(CLK_DIV - 1);
    h_last = h_q == 10'(HT - 1);
    div_d = tick ? '0 : div_q + 1'b1;
    h_d = tick ? (h_last ? '0 : h_q + 10'd1) : h_q;
    v_d = (tick && h_last) ? (v_q == 10'(VT - 1) ? '0 : v_q + 10'd1) : v_q;
  end
  // Raw timing decode straight from the counters
  always_comb begin
    active = h_q < 10'(H_ACTIVE) && v_q < 10'(V_ACTIVE);
    hs = h_q >= 10'(HS0) && h_q < 10'(HS0 + H_SYNC);
    vs = v_q >= 10'(VS0) && v_q < 10'(VS0 + V_SYNC);
    vb = v_q >= 10'(V_ACTIVE);
  end
  delay_line #(.WIDTH(4), .DEPTH(MEM_LAT)) u_align (
    .clk(clk), .rst(rst), .d({active, hs, vs, vb}), .q(flags_a)
  );
  assign {active_a, hs_a, vs_a, vb_a} = flags_a;
`ifdef VGA_TEST_PATTERN_EN
  logic [2:0] bar_a;
  delay_line #(.WIDTH(3), .DEPTH(MEM_LAT)) u_bar (
    .clk(clk), .rst(rst), .d(h_q[9:7]), .q(bar_a)
  );
  assign src = bar_color(bar_a);
`else
  assign src = pixel;
`endif
  // Output stage: blank colour outside the visible area, apply sync polarity
  always_comb begin
    rgb_d = active_a ? src : '0;
    hsync_d = hs_a ^ ~SYNC_POL;
    vsync_d = vs_a ^ ~SYNC_POL;
    vblank_d = vb_a;
  end
  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
      h_q <= '0;
      v_q <= '0;
      rgb_q <= '0;
      hsync_q <= ~SYNC_POL;
      vsync_q <= ~SYNC_POL;
      vblank_q <= 1'b0;
    end else begin
      div_q <= div_d;
      h_q <= h_d;
      v_q <= v_d;
      rgb_q <= rgb_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      vblank_q <= vblank_d;
    end
  end
  assign pixel_x = h_q;
  assign pixel_y = v_q;
  assign {vga_r, vga_g, vga_b} = rgb_q;
  assign vga_hsync = hsync_q;
  assign vga_vsync = vsync_q;
  assign vblank = vblank_q;
endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout: checks scan timing, alignment and blanking against a time-based model
module tb_vga_scanout;
  localparam int CD = 4;
  localparam int HA = 640, HF = 16, HS = 96, HB = 48;
  localparam int VA = 3, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int LAT = 3;

  typedef struct packed {logic [11:0] rgb; logic hs; logic vs; logic vb;} pins_t;
  typedef struct {int k; int x; int y; logic [11:0] rgb; logic hs; logic vs; logic vb;} vec_t;

  logic clk = 1'b0, rst = 1'b1;
  logic [9:0] pixel_x, pixel_y, mx1, my1, mx2, my2;
  logic [11:0] pixel;
  logic [3:0] vga_r, vga_g, vga_b;
  logic vga_hsync, vga_vsync, vblank;
  logic [11:0] lut [1024];
  int k = 0, mode = 0, n_chk = 0, n_fail = 0;
  bit chk_en = 1'b0;
  time skip_t = 0;
  vec_t tbl [22];

  vga_scanout #(
    .CLK_DIV(CD), .MEM_LAT(2),
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel(pixel),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .vblank(vblank)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] pix_fn(input logic [9:0] x, input logic [9:0] y, input int m);
    logic [9:0] idx = x + 10'(y * 37);
    return m == 0 ? {x[3:0], y[3:0], 4'hA} : m == 1 ? 12'hFFF : lut[idx];
  endfunction

  // memory block stand-in: two register stages from coordinates to pixel
  always @(posedge clk) begin
    mx1 <= pixel_x; my1 <= pixel_y;
    mx2 <= mx1;     my2 <= my1;
  end
  assign pixel = pix_fn(mx2, my2, mode);

  // clocks since the last reset edge
  always @(posedge clk) k <= rst ? 0 : k + 1;

  function automatic pins_t model(input int kk, input int m);
    pins_t e;
    int p, h, v;
    bit act;
    e = '{rgb: 12'h000, hs: 1'b1, vs: 1'b1, vb: 1'b0};
    if (kk < LAT) return e;
    p = (kk - LAT) / CD;
    h = p % HT;
    v = (p / HT) % VT;
    act = h < HA && v < VA;
`ifdef VGA_TEST_PATTERN_EN
    begin
      logic [11:0] bars [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};
      e.rgb = act ? bars[h / 128] : 12'h000;
    end
`else
    e.rgb = act ? pix_fn(10'(h), 10'(v), m) : 12'h000;
`endif
    e.hs = !(h >= HA + HF && h < HA + HF + HS);
    e.vs = !(v >= VA + VF && v < VA + VF + VS);
    e.vb = v >= VA;
    return e;
  endfunction

  function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (k=%0d t=%0t)", name, got, exp, k, $time);
    end
  endfunction

  // continuous comparison of every clock against the model
  always @(negedge clk) begin
    pins_t e;
    int p;
    if (chk_en) begin
      p = k / CD;
      chk("coords", {12'h0, pixel_x, pixel_y}, {12'h0, 10'(p % HT), 10'((p / HT) % VT)});
      e = model(k, mode);
      chk("syncs", {29'h0, vga_hsync, vga_vsync, vblank}, {29'h0, e.hs, e.vs, e.vb});
      if ($time >= skip_t) chk("rgb", {20'h0, vga_r, vga_g, vga_b}, {20'h0, e.rgb});
    end
  end

  task automatic wait_k(input int target);
    int g = 0;
    while (k < target && g < 40000) begin
      @(negedge clk);
      g++;
    end
    if (k < target) chk("timeout_k", k, target);
  endtask

  task automatic set_mode(input int m);
    @(posedge clk);
    #1;
    mode = m;
    skip_t = $time + 40;
  endtask

  initial begin
    int g, n;
    for (int i = 0; i < 1024; i++) lut[i] = 12'($urandom);
    tbl = '{
      '{0,     0,   0, 12'h000, 1'b1, 1'b1, 1'b0},
      '{2,     0,   0, 12'h000, 1'b1, 1'b1, 1'b0},
      '{3,     0,   0, 12'h00A, 1'b1, 1'b1, 1'b0},
      '{4,     1,   0, 12'h00A, 1'b1, 1'b1, 1'b0},
      '{7,     1,   0, 12'h10A, 1'b1, 1'b1, 1'b0},
      '{2559,  639, 0, 12'hF0A, 1'b1, 1'b1, 1'b0},
      '{2563,  640, 0, 12'h000, 1'b1, 1'b1, 1'b0},
      '{2626,  656, 0, 12'h000, 1'b1, 1'b1, 1'b0},
      '{2627,  656, 0, 12'h000, 1'b0, 1'b1, 1'b0},
      '{3010,  752, 0, 12'h000, 1'b0, 1'b1, 1'b0},
      '{3011,  752, 0, 12'h000, 1'b1, 1'b1, 1'b0},
      '{3199,  799, 0, 12'h000, 1'b1, 1'b1, 1'b0},
      '{3200,  0,   1, 12'h000, 1'b1, 1'b1, 1'b0},
      '{3203,  0,   1, 12'h01A, 1'b1, 1'b1, 1'b0},
      '{6423,  5,   2, 12'h52A, 1'b1, 1'b1, 1'b0},
      '{9602,  0,   3, 12'h000, 1'b1, 1'b1, 1'b0},
      '{9603,  0,   3, 12'h000, 1'b1, 1'b1, 1'b1},
      '{12803, 0,   4, 12'h000, 1'b1, 1'b0, 1'b1},
      '{16002, 0,   5, 12'h000, 1'b1, 1'b0, 1'b1},
      '{16003, 0,   5, 12'h000, 1'b1, 1'b1, 1'b1},
      '{19200, 0,   0, 12'h000, 1'b1, 1'b1, 1'b1},
      '{19203, 0,   0, 12'h00A, 1'b1, 1'b1, 1'b0}
    };
    @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    rst = 1'b0;
    for (int i = 0; i < 22; i++) begin
      wait_k(tbl[i].k);
      chk("tbl_x", pixel_x, tbl[i].x);
      chk("tbl_y", pixel_y, tbl[i].y);
      chk("tbl_sync", {vga_hsync, vga_vsync, vblank}, {tbl[i].hs, tbl[i].vs, tbl[i].vb});
`ifndef VGA_TEST_PATTERN_EN
      chk("tbl_rgb", {vga_r, vga_g, vga_b}, tbl[i].rgb);
`endif
    end
    set_mode(1);
    g = 0;
    while (vga_hsync && g < 4000) begin
      @(negedge clk);
      g++;
    end
    chk("hs_start", k, 19200 + 2627);
    n = 0;
    while (!vga_hsync && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("hs_width", n, 384);
    wait_k(26800);
    chk("pre_rst_x", pixel_x, 300);
    chk("pre_rst_y", pixel_y, 2);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_x", pixel_x, 0);
    chk("rst_y", pixel_y, 0);
    chk("rst_hs", vga_hsync, 1);
    chk("rst_vs", vga_vsync, 1);
    chk("rst_rgb", {vga_r, vga_g, vga_b}, 0);
    chk("rst_vb", vblank, 0);
    rst = 1'b0;
    set_mode(2);
    repeat ($urandom_range(5000, 2000)) @(negedge clk);
    rst = 1'b1;
    repeat ($urandom_range(3, 1)) @(negedge clk);
    rst = 1'b0;
    wait_k(13000);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
